// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Summary  : Instruction fetch stage: single-outstanding memory request FSM
//            feeding a small FIFO of {pc, instruction} pairs. Defining
//            IF_BYPASS_EN presents an ack to an empty buffer in the same cycle.
// Revision : 1.0
// ============================================================================
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic        stall,
    output logic        if_valid,
    output logic [63:0] pc,
    output logic [31:0] instruction
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam logic [31:0]        c_NOP     = 32'h0000_0013;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
    localparam logic [c_PTR_W:0]   c_CNT_ONE = 1;
    localparam logic [c_PTR_W:0]   c_CNT_MAX = DEPTH[c_PTR_W:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_req;
    logic [63:0]        r_addr;
    logic [63:0]        r_fetch_pc;
    logic [63:0]        r_buf_pc  [DEPTH];
    logic [31:0]        r_buf_ins [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_PTR_W:0]   r_count;

    state_t             w_state_next;
    logic [63:0]        w_fetch_pc_next;
    logic [63:0]        w_target;
    logic [c_PTR_W:0]   w_count_next;
    logic               w_ack;
    logic               w_hold;
    logic               w_buf_valid;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic               w_req_next;
    logic               w_unused;

    assign w_target    = {branch_target[63:2], 2'b00};
    assign w_unused    = ^branch_target[1:0];
    assign w_ack       = r_req & imem_ack;
    assign w_hold      = r_req & ~imem_ack;
    assign w_buf_valid = (r_count != '0);

`ifdef IF_BYPASS_EN
    assign w_bypass = (r_state == FETCH) & w_ack & ~w_buf_valid & ~branch_taken;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed word consumed by decode this cycle never enters the buffer.
    assign w_push = (r_state == FETCH) & w_ack & ~branch_taken & ~(w_bypass & ~stall);
    assign w_pop  = w_buf_valid & ~stall & ~branch_taken;

    always_comb begin
        w_count_next = r_count;
        if (branch_taken) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_CNT_ONE;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        case (r_state)
            IDLE:    w_state_next = FETCH;
            FETCH:   if (branch_taken && w_hold) w_state_next = FLUSH;
            FLUSH:   if (w_ack) w_state_next = FETCH;
            default: w_state_next = IDLE;
        endcase
        if (branch_taken) begin
            w_fetch_pc_next = w_target;
        end else if (r_state == FETCH && w_ack) begin
            w_fetch_pc_next = r_fetch_pc + 64'd4;
        end
    end

    // An unacked request is held as-is; otherwise a new one is raised only if
    // the buffer can still absorb its data.
    assign w_req_next = w_hold | ((w_state_next == FETCH) && (w_count_next < c_CNT_MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_req      <= w_req_next;
            r_fetch_pc <= w_fetch_pc_next;
            if (!w_hold) begin
                r_addr <= w_fetch_pc_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_pc[i]  <= '0;
                r_buf_ins[i] <= c_NOP;
            end
        end else begin
            r_count <= w_count_next;
            if (branch_taken) begin
                r_head <= r_tail;
            end else begin
                if (w_push) begin
                    r_buf_pc[r_tail]  <= r_addr;
                    r_buf_ins[r_tail] <= imem_rdata;
                    r_tail            <= r_tail + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_head <= r_head + c_PTR_ONE;
                end
            end
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;

`ifdef IF_BYPASS_EN
    assign if_valid    = w_buf_valid | w_bypass;
    assign pc          = w_bypass ? r_addr : r_buf_pc[r_head];
    assign instruction = w_bypass ? imem_rdata : r_buf_ins[r_head];
`else
    assign if_valid    = w_buf_valid;
    assign pc          = r_buf_pc[r_head];
    assign instruction = r_buf_ins[r_head];
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Summary  : Scoreboard bench for if_stage: memory model, redirect stimulus
//            and an expected in-order instruction stream per redirect.
// Revision : 1.0
// ============================================================================
module tb_if_stage;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef IF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk           = 1'b0;
    logic        reset         = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack      = 1'b0;
    logic [31:0] imem_rdata    = 32'hDEAD_BEEF;
    logic        branch_taken  = 1'b0;
    logic [63:0] branch_target = '0;
    logic        stall         = 1'b0;
    logic        if_valid;
    logic [63:0] pc;
    logic [31:0] instruction;

    int errors   = 0;
    int checks   = 0;
    int mem_mode = 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic        prev_hold = 1'b0;
    logic [63:0] prev_addr = '0;
    logic [63:0] old_addr;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .if_valid      (if_valid),
        .pc            (pc),
        .instruction   (instruction)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[33:2] ^ a[63:32] ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Any redirect (reset release or branch) restarts the expected stream.
    task automatic expect_stream(input logic [63:0] start);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 1024; i++) begin
            e.pc  = start + 64'(4 * i);
            e.ins = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_mem();
        if (imem_req && (mem_mode == 1 || (mem_mode == 0 && $urandom_range(1, 0) == 1))) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        drive_mem();
    endtask

    task automatic do_branch(input logic [63:0] t);
        branch_taken  = 1'b1;
        branch_target = t;
        expect_stream({t[63:2], 2'b00});
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        if (!imem_req) begin
            checks++;
            errors++;
            $display("FAIL %s: imem_req still 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset        = 1'b1;
        branch_taken = 1'b0;
        expect_stream(RST_PC);
        drive_mem();
    endtask

    // Monitor: every presented pair must match the head of the expected stream;
    // it is retired only when decode accepts it.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            if (prev_hold) begin
                check("req_held", 64'(imem_req), 64'd1);
                check("addr_held", imem_addr, prev_addr);
            end
            if (if_valid && !branch_taken) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got pc %h, expected no presented instruction", pc);
                end else begin
                    mon_e = exp_q[0];
                    check("sb_pc", pc, mon_e.pc);
                    check("sb_ins", 64'(instruction), 64'(mon_e.ins));
                    if (!stall) void'(exp_q.pop_front());
                end
            end
        end
        prev_hold = reset && imem_req && !imem_ack;
        prev_addr = imem_addr;
    end

    initial begin
        mem_mode = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_valid", 64'(if_valid), 64'd0);
        check("rst_pc", pc, 64'd0);
        check("rst_ins", 64'(instruction), 64'(NOP));

        // Reset release with memory acking every cycle.
        release_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("seq_req", 64'(imem_req), 64'd1);
            check("seq_addr", imem_addr, RST_PC + 64'(4 * i));
            check("seq_valid", 64'(if_valid), 64'(BYP || i > 0));
            if (BYP || i > 0)
                check("seq_pc", pc, BYP ? RST_PC + 64'(4 * i) : RST_PC + 64'(4 * (i - 1)));
        end

        // Decode stalls long enough for the buffer to fill.
        step();
        stall = 1'b1;
        repeat (5) step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_req", 64'(imem_req), 64'd0);
            check("stall_valid", 64'(if_valid), 64'd1);
            if (exp_q.size() > 0) check("stall_pc", pc, exp_q[0].pc);
            step();
        end

        // Redirect while a request is pending; memory answers two cycles later.
        stall    = 1'b0;
        mem_mode = 2;
        wait_req("flush_wait");
        old_addr = imem_addr;
        do_branch(64'h2002);
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            check("flush_req", 64'(imem_req), 64'd1);
            check("flush_addr", imem_addr, old_addr);
            check("flush_valid", 64'(if_valid), 64'd0);
        end
        step();
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        @(negedge clk);
        check("flush_ack_valid", 64'(if_valid), 64'd0);
        step();
        @(negedge clk);
        check("tgt_req", 64'(imem_req), 64'd1);
        check("tgt_addr", imem_addr, 64'h2000);
        check("tgt_valid", 64'(if_valid), 64'd0);
        mem_mode = 1;
        step();
        @(negedge clk);
        check("tgt_valid1", 64'(if_valid), 64'(BYP));
        step();
        @(negedge clk);
        check("tgt_valid2", 64'(if_valid), 64'd1);
        check("tgt_pc", pc, BYP ? 64'h2004 : 64'h2000);

        // Redirect in the same cycle as an ack.
        step();
        wait_req("br_ack_wait");
        do_branch(64'h3000);
        step();
        @(negedge clk);
        check("brack_req", 64'(imem_req), 64'd1);
        check("brack_addr", imem_addr, 64'h3000);
        check("brack_valid", 64'(if_valid), 64'(BYP));

        // Address wrap at the top of the 64-bit space.
        step();
        do_branch(64'hFFFF_FFFF_FFFF_FFF8);
        step();
        if (!BYP) step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("wrap_valid", 64'(if_valid), 64'd1);
            check("wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFF8 + 64'(4 * k));
            step();
        end

        // Reset asserted between edges with a request outstanding.
        mem_mode = 2;
        wait_req("rst_mid_wait");
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_req", 64'(imem_req), 64'd0);
        check("midrst_valid", 64'(if_valid), 64'd0);
        check("midrst_addr", imem_addr, RST_PC);
        check("midrst_pc", pc, 64'd0);
        check("midrst_ins", 64'(instruction), 64'(NOP));
        repeat (2) step();
        release_reset();

        // Randomised traffic: ack latency, stalls and redirects.
        mem_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            step();
            stall = ($urandom_range(3, 0) == 0);
            if ($urandom_range(23, 0) == 0) begin
                case ($urandom_range(3, 0))
                    0:       do_branch({$urandom(), $urandom()});
                    1:       do_branch(64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0)));
                    2:       do_branch(64'h2000 + 64'($urandom_range(63, 0)));
                    default: do_branch(RST_PC);
                endcase
            end
        end
        step();
        stall = 1'b0;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
